// File: rtl/arm6_dmem.sv
// rtl/arm6_dmem.sv - ARM6 data-memory responder with programmable wait states
// Optional feature: define ARM6_DMEM_ALIGN_CHECK_EN to also abort misaligned
// addresses and lane masks that are not a byte, aligned halfword or full word.
module arm6_dmem #(
  parameter int          AW   = 10,
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter int          WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ram_addr,
  input  logic        ram_cen,
  input  logic        ram_wen,
  input  logic [3:0]  ram_flag,
  input  logic [31:0] ram_wdata,
  output logic [31:0] ram_rdata,
  output logic        ram_abort,
  output logic        cpu_en
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_WAIT   = 1'b1;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] l_addr;
  logic        l_wen;
  logic [3:0]  l_flag;
  logic [31:0] l_wdata;

  logic [31:0] mem [0:(1<<AW)-1];

  logic [31:0] acc_addr;
  logic        acc_wen;
  logic [3:0]  acc_flag;
  logic [31:0] acc_wdata;
  logic        do_acc;
  logic        bad;
  logic [32:0] diff;
  logic [31:0] offset;
  logic [AW-1:0] idx;

  // Select live port or latched request, decide whether an access fires this edge, range-check it
  always_comb begin
    if (state == S_WAIT) begin
      acc_addr  = l_addr;
      acc_wen   = l_wen;
      acc_flag  = l_flag;
      acc_wdata = l_wdata;
      do_acc    = (cnt == 4'd1);
    end else begin
      acc_addr  = ram_addr;
      acc_wen   = ram_wen;
      acc_flag  = ram_flag;
      acc_wdata = ram_wdata;
      do_acc    = !ram_cen && (WAIT_CNT == 4'd0);
    end
    // bit 32 of the widened difference is the borrow, i.e. addr below BASE
    diff   = {1'b0, acc_addr} - {1'b0, BASE};
    offset = diff[31:0];
    idx    = offset[AW+1:2];
    bad    = diff[32] || ((offset >> (AW + 2)) != 32'd0);
`ifdef ARM6_DMEM_ALIGN_CHECK_EN
    if (acc_addr[1:0] != 2'b00) bad = 1'b1;
    case (acc_flag)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: ;
      default: bad = 1'b1;
    endcase
`endif
  end

  // Request sequencing, wait-state countdown and the registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      cpu_en    <= 1'b1;
      ram_rdata <= 32'd0;
      ram_abort <= 1'b0;
      l_addr    <= 32'd0;
      l_wen     <= 1'b1;
      l_flag    <= 4'd0;
      l_wdata   <= 32'd0;
    end else begin
      ram_abort <= 1'b0;
      if (do_acc) begin
        if (bad) begin
          ram_rdata <= 32'd0;
          ram_abort <= 1'b1;
        end else if (acc_wen) begin
          ram_rdata <= mem[idx];
        end
      end
      case (state)
        S_IDLE: begin
          if (!ram_cen) begin
            l_addr  <= ram_addr;
            l_wen   <= ram_wen;
            l_flag  <= ram_flag;
            l_wdata <= ram_wdata;
            if (WAIT_CNT != 4'd0) begin
              cnt    <= WAIT_CNT;
              state  <= S_WAIT;
              cpu_en <= 1'b0;
            end
          end
        end
        default: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state  <= S_IDLE;
            cpu_en <= 1'b1;
          end
        end
      endcase
    end
  end

  // Byte-lane write; array is never cleared, and no write lands while reset is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
    end else if (do_acc && !bad && !acc_wen) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_flag[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_arm6_dmem.sv
// tb/tb_arm6_dmem.sv - self-checking bench for arm6_dmem (WAIT=0 and WAIT=2 instances)
module tb_arm6_dmem;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_cen, a_wen, a_abort, a_cpu_en;
  logic [3:0]  a_flag;
  logic [31:0] z_addr, z_wdata, z_rdata;
  logic        z_cen, z_wen, z_abort, z_cpu_en;
  logic [3:0]  z_flag;

  arm6_dmem #(.AW(10), .BASE(32'h0), .WAIT(2)) u_a (
    .clk(clk), .rst(rst), .ram_addr(a_addr), .ram_cen(a_cen), .ram_wen(a_wen),
    .ram_flag(a_flag), .ram_wdata(a_wdata), .ram_rdata(a_rdata),
    .ram_abort(a_abort), .cpu_en(a_cpu_en));

  arm6_dmem #(.AW(10), .BASE(32'h0), .WAIT(0)) u_z (
    .clk(clk), .rst(rst), .ram_addr(z_addr), .ram_cen(z_cen), .ram_wen(z_wen),
    .ram_flag(z_flag), .ram_wdata(z_wdata), .ram_rdata(z_rdata),
    .ram_abort(z_abort), .cpu_en(z_cpu_en));

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference model for the WAIT=2 instance: word store keyed by word index, last response
  logic [31:0] ma [int];
  logic [31:0] la = 32'd0;

  function automatic bit ref_abort(input logic [31:0] a, input logic [3:0] f);
    if (a >= 32'h1000) return 1'b1;
`ifdef ARM6_DMEM_ALIGN_CHECK_EN
    if (a % 4 != 0) return 1'b1;
    if (!(f inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic ref_step(input logic [31:0] a, input logic wen, input logic [3:0] f,
                          input logic [31:0] d, output logic [31:0] erd, output logic eab);
    int w;
    logic [31:0] word;
    w = int'(a / 4);
    if (ref_abort(a, f)) begin
      erd = 32'd0;
      eab = 1'b1;
    end else begin
      eab  = 1'b0;
      word = ma.exists(w) ? ma[w] : 32'd0;
      if (wen) begin
        erd = word;
      end else begin
        erd = la;
        for (int i = 0; i < 4; i++) if (f[i]) word[8*i +: 8] = d[8*i +: 8];
        ma[w] = word;
      end
    end
    la = erd;
  endtask

  // Issue one request on the chosen instance; returns response and number of stalled cycles
  task automatic access(input bit z, input logic [31:0] a, input logic wen, input logic [3:0] f,
                        input logic [31:0] d, output logic [31:0] rd, output logic ab, output int stall);
    if (z) begin
      z_addr = a; z_cen = 1'b0; z_wen = wen; z_flag = f; z_wdata = d;
    end else begin
      a_addr = a; a_cen = 1'b0; a_wen = wen; a_flag = f; a_wdata = d;
    end
    @(negedge clk);
    if (z) z_cen = 1'b1;
    else begin
      // port must be ignored while the latched request is in flight
      a_addr = $urandom; a_wdata = $urandom; a_flag = 4'($urandom);
      a_wen = 1'($urandom); a_cen = 1'($urandom);
    end
    stall = 0;
    while ((z ? z_cpu_en : a_cpu_en) !== 1'b1 && stall < 20) begin
      stall++;
      @(negedge clk);
    end
    a_cen = 1'b1;
    if (stall >= 20) check("timeout_cpu_en", 32'(stall), 32'd0);
    rd = z ? z_rdata : a_rdata;
    ab = z ? z_abort : a_abort;
  endtask

  task automatic run_ref(input logic [31:0] a, input logic wen, input logic [3:0] f, input logic [31:0] d);
    logic [31:0] erd, rd;
    logic eab, ab;
    int stall;
    ref_step(a, wen, f, d, erd, eab);
    access(1'b0, a, wen, f, d, rd, ab, stall);
    check("rand_rdata", rd, erd);
    check("rand_abort", 32'(ab), 32'(eab));
    check("rand_stall", 32'(stall), 32'd2);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  flag;
    logic [31:0] wdata;
    logic [31:0] erd;
    logic        eab;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [31:0] rd;
    logic ab;
    int stall;

    tbl[0]  = '{32'h10,   1'b0, 4'hF, 32'h12345678, 32'h0,        1'b0};
    tbl[1]  = '{32'h10,   1'b1, 4'hF, 32'h0,        32'h12345678, 1'b0};
    tbl[2]  = '{32'h1000, 1'b1, 4'hF, 32'h0,        32'h0,        1'b1};
    tbl[3]  = '{32'hFFC,  1'b0, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0};
    tbl[4]  = '{32'hFFC,  1'b1, 4'hF, 32'h0,        32'hCAFEF00D, 1'b0};
`ifdef ARM6_DMEM_ALIGN_CHECK_EN
    tbl[5]  = '{32'h10,   1'b0, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b1};
`else
    tbl[5]  = '{32'h10,   1'b0, 4'h0, 32'hFFFFFFFF, 32'hCAFEF00D, 1'b0};
`endif
    tbl[6]  = '{32'h10,   1'b1, 4'hF, 32'h0,        32'h12345678, 1'b0};
    tbl[7]  = '{32'h8,    1'b0, 4'hF, 32'h11223344, 32'h12345678, 1'b0};
`ifdef ARM6_DMEM_ALIGN_CHECK_EN
    tbl[8]  = '{32'h8,    1'b0, 4'h5, 32'hAABBCCDD, 32'h0,        1'b1};
    tbl[9]  = '{32'h9,    1'b1, 4'hF, 32'h0,        32'h0,        1'b1};
    tbl[10] = '{32'h8,    1'b1, 4'hF, 32'h0,        32'h11223344, 1'b0};
`else
    tbl[8]  = '{32'h8,    1'b0, 4'h5, 32'hAABBCCDD, 32'h12345678, 1'b0};
    tbl[9]  = '{32'h9,    1'b1, 4'hF, 32'h0,        32'h11BB33DD, 1'b0};
    tbl[10] = '{32'h8,    1'b1, 4'hF, 32'h0,        32'h11BB33DD, 1'b0};
`endif

    a_addr = 0; a_cen = 1'b1; a_wen = 1'b1; a_flag = 0; a_wdata = 0;
    z_addr = 0; z_cen = 1'b1; z_wen = 1'b1; z_flag = 0; z_wdata = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_a_rdata", a_rdata, 32'h0);
    check("reset_a_abort", 32'(a_abort), 32'd0);
    check("reset_a_cpu_en", 32'(a_cpu_en), 32'd1);
    check("reset_z_rdata", z_rdata, 32'h0);
    check("reset_z_abort", 32'(z_abort), 32'd0);
    check("reset_z_cpu_en", 32'(z_cpu_en), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Table on the zero-wait instance
    for (int i = 0; i < 11; i++) begin
      access(1'b1, tbl[i].addr, tbl[i].wen, tbl[i].flag, tbl[i].wdata, rd, ab, stall);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].erd);
      check($sformatf("tbl%0d_abort", i), 32'(ab), 32'(tbl[i].eab));
      check($sformatf("tbl%0d_stall", i), 32'(stall), 32'd0);
    end

    // Abort is a single-cycle pulse
    access(1'b1, 32'h1000, 1'b1, 4'hF, 32'h0, rd, ab, stall);
    check("z_abort_pulse", 32'(ab), 32'd1);
    @(negedge clk);
    check("z_abort_clear", 32'(z_abort), 32'd0);
    check("z_abort_rdata_hold", z_rdata, 32'h0);

    // Wait-state instance: merge of partial write
    access(1'b0, 32'h20, 1'b0, 4'hF, 32'hAABBCCDD, rd, ab, stall);
    check("w2_wr1_stall", 32'(stall), 32'd2);
    check("w2_wr1_abort", 32'(ab), 32'd0);
    access(1'b0, 32'h20, 1'b0, 4'h1, 32'h00000011, rd, ab, stall);
    check("w2_wr2_stall", 32'(stall), 32'd2);
    access(1'b0, 32'h20, 1'b1, 4'hF, 32'h0, rd, ab, stall);
    check("w2_rd_merge", rd, 32'hAABBCC11);
    check("w2_rd_stall", 32'(stall), 32'd2);

    // Wait-state instance: abort with clear on next edge
    access(1'b0, 32'h1000, 1'b1, 4'hF, 32'h0, rd, ab, stall);
    check("w2_abort", 32'(ab), 32'd1);
    check("w2_abort_rdata", rd, 32'h0);
    @(negedge clk);
    check("w2_abort_clear", 32'(a_abort), 32'd0);

    // Reset during an in-flight write drops the write
    access(1'b0, 32'h40, 1'b0, 4'hF, 32'h55667788, rd, ab, stall);
    access(1'b0, 32'h20, 1'b1, 4'hF, 32'h0, rd, ab, stall);
    check("w2_rd_before_rst", rd, 32'hAABBCC11);
    a_addr = 32'h40; a_cen = 1'b0; a_wen = 1'b0; a_flag = 4'hF; a_wdata = 32'h99999999;
    @(negedge clk);
    a_cen = 1'b1;
    check("inflight_cpu_en", 32'(a_cpu_en), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_cpu_en", 32'(a_cpu_en), 32'd1);
    check("rst_async_rdata", a_rdata, 32'h0);
    check("rst_async_abort", 32'(a_abort), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cpu_en", 32'(a_cpu_en), 32'd1);
    access(1'b0, 32'h40, 1'b1, 4'hF, 32'h0, rd, ab, stall);
    check("post_rst_rd40", rd, 32'h55667788);
    check("post_rst_stall", 32'(stall), 32'd2);

    // Randomized traffic against the reference model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ma.delete();
    la = 32'd0;
    for (int w = 0; w < 32; w++) run_ref(32'(w * 4), 1'b0, 4'hF, $urandom);
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h1000;
      else a = 32'($urandom_range(0, 127));
      run_ref(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arm6_dmem.md
# arm6_dmem

Data-memory responder for the ARM6 core's `ram_*` port: the target end of the interface the core drives as initiator. It samples each core request, enforces a programmable number of wait states by deasserting `cpu_en`, performs a byte-lane-masked read or write on an internal word array, and returns `ram_rdata` and `ram_abort`. It sits between the core and the on-chip SRAM, beside the instruction ROM.

## Interface
- `AW`, 10: word-address width; the array holds 2^AW 32-bit words.
- `BASE`, 32'h0000_0000: byte address of word 0; must be aligned to 4·2^AW.
- `WAIT`, 1: wait states per access, 0..15.

Ports. Clock and reset are one clock and one asynchronous active-high reset, as decided: `clk`, `rst`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous active-high reset.
- `ram_addr` in 32: byte address of the request.
- `ram_cen` in 1: chip enable, active low; a request is present when it is 0.
- `ram_wen` in 1: write enable, active low; 0 means write, 1 means read.
- `ram_flag` in 4: byte-lane enables, active high; bit i selects byte i.
- `ram_wdata` in 32: write data.
- `ram_rdata` out 32: read data, registered.
- `ram_abort` out 1: data abort, registered, one-cycle pulse with the response.
- `cpu_en` out 1: core advance enable, registered; 0 stalls the core.

## Operation
- States: IDLE, WAIT.
- IDLE, `ram_cen`=0 at an edge: latch addr, wen, flag and wdata.
  - `WAIT`=0: perform the access at that edge and stay in IDLE.
  - `WAIT`>0: load `cnt`=`WAIT`, go to WAIT and drive `cpu_en`=0.
- WAIT: decrement `cnt` each edge. At the edge where `cnt`=1, perform the latched access, set `cpu_en`=1 and return to IDLE.
- Port inputs are ignored in WAIT; the latched copy is used.
- Range check:
  - Offset = `ram_addr`−`BASE`.
  - Abort if `ram_addr`<`BASE` or offset ≥ 4·2^AW.
  - Word index = offset[AW+1:2].
- Read: `ram_rdata` = the full stored word, regardless of `ram_flag`; `ram_abort`=0.
- Write:
  - Only lanes whose `ram_flag` bit is 1 are updated.
  - `ram_rdata` is unchanged; `ram_abort`=0.
  - `ram_flag`=0000 is a no-op with no abort.
- Abort:
  - Array unchanged.
  - `ram_rdata`=0 and `ram_abort`=1 for exactly one cycle.
- `ram_abort` returns to 0 on the next edge unless a new response aborts.
- Back-to-back requests are accepted on consecutive IDLE edges.
- A read issued after a write to the same word returns the written lanes merged with the old lanes.
- Reset:
  - Outputs go to `ram_rdata`=0, `ram_abort`=0, `cpu_en`=1; state IDLE, `cnt`=0.
  - An in-flight access is dropped and no write occurs.
  - Array contents are not reset and are undefined until written.

## Timing
- Request sampled at edge N.
- `WAIT`=0: response is valid from N to N+1; `cpu_en` stays 1.
- `WAIT`=k:
  - `cpu_en`=0 from N to N+k, i.e. k cycles.
  - Response and `cpu_en`=1 are valid from N+k.
  - The next request is sampleable at edge N+k+1.
- Latency, request edge to response-valid edge: `WAIT` cycles; zero means the response is registered at the same edge.
- `rst` assertion takes effect immediately (asynchronous). Deassertion is synchronous to `clk` from the core's reset synchronizer.

## Configuration
- `ARM6_DMEM_ALIGN_CHECK_EN` defined: additionally abort when either
  - `ram_addr[1:0]`≠0, or
  - `ram_flag` ∉ {0001, 0010, 0100, 1000, 0011, 1100, 1111} (flag 0000 aborts too).
- Undefined: `ram_addr[1:0]` is ignored and any `ram_flag` value is accepted, per the rules above.

## Test plan
- `WAIT`=0, write 0x12345678 flag 1111 to 0x10, then read 0x10: rdata=0x12345678 one cycle after the read edge; `cpu_en` never 0; abort 0.
- `WAIT`=2:
  - Write 0xAABBCCDD flag 1111 to 0x20, then write 0x00000011 flag 0001 to 0x20.
  - Read 0x20: rdata=0xAABBCC11.
  - Each access holds `cpu_en`=0 for exactly 2 cycles.
- `AW`=10, `BASE`=0, read 0x1000: `ram_abort`=1 for one cycle, rdata=0. Then read 0x0FFC: abort 0.
- `WAIT`=3, assert `rst` one cycle after a write request to 0x40: `cpu_en`=1, outputs 0, state IDLE. A subsequent read of 0x40 shows the pre-reset contents, i.e. the write did not happen.
- Macro defined:
  - Write flag 0101 to 0x8: abort, word unchanged.
  - Read 0x9: abort.
  - Macro undefined: the same two accesses complete without abort.
